seg_scan_driver: RTL and testbench

Time-multiplexed driver for the eight-digit seven-segment display. Consumes the eight active-low segment patterns produced by the display/blink formatting stage and drives the shared segment bus and per-digit anode enables. Provides a guard interval against ghosting, frame-coherent capture of the patterns, and a per-frame strobe. Sits between the formatting stage and the board pins.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/seg_slot_timer.sv | 59 +++++
 rtl/seg_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared display constants and types for the seven-segment scan path.
// Digit index type, dark pattern and scan phase encoding.
package clock_pkg;

   localparam logic [6:0] SEG_DARK = 7'h7F;
   localparam int         N_DIGITS = 8;

   typedef logic [2:0] dig_t;

   typedef enum logic {
      PH_GUARD,
      PH_ON
   } phase_e;

   function automatic logic [N_DIGITS-1:0] dig_onehot(input dig_t d);
      dig_onehot    = '0;
      dig_onehot[d] = 1'b1;
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter, digit index, guard/on phase decode and frame strobe
// for the multiplexed seven-segment scanner.
module seg_slot_timer
   import clock_pkg::*;
#(
   parameter int SLOT_CYC  = 50000,
   parameter int GUARD_CYC = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   output dig_t   dig_o,
   output phase_e phase_o,
   output logic   frame_wrap_o,
   output logic   frame_tick_o
);

   localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] GUARD_LEN = CNT_W'(GUARD_CYC);
   localparam dig_t DIG_LAST = dig_t'(N_DIGITS - 1);

   logic [CNT_W-1:0] slot_cnt_q;
   logic [CNT_W-1:0] slot_cnt_d;
   dig_t             dig_q;
   dig_t             dig_d;
   logic             slot_last;
   logic             tick_d;
   logic             tick_q;

   always_comb begin
      slot_last  = (slot_cnt_q == SLOT_LAST);
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
      dig_d      = dig_q;
      if (slot_last) begin
         slot_cnt_d = '0;
         dig_d      = dig_q + 3'd1;
      end
      // Registered so the strobe lines up with the first blanked output cycle
      tick_d = (slot_cnt_q == '0) && (dig_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q <= '0;
         dig_q      <= '0;
         tick_q     <= 1'b0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         dig_q      <= dig_d;
         tick_q     <= tick_d;
      end
   end

   assign dig_o        = dig_q;
   assign phase_o      = (slot_cnt_q < GUARD_LEN) ? PH_GUARD : PH_ON;
   assign frame_wrap_o = slot_last && (dig_q == DIG_LAST);
   assign frame_tick_o = tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan driver with frame-coherent shadows.
// Optional brightness PWM is enabled with the SEG_DIM_EN macro.
module seg_scan_driver
   import clock_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int SCAN_HZ       = 1000,
   parameter int GUARD_CYC     = 16,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] led0,
   input  logic [6:0] led1,
   input  logic [6:0] led2,
   input  logic [6:0] led3,
   input  logic [6:0] led4,
   input  logic [6:0] led5,
   input  logic [6:0] led6,
   input  logic [6:0] led7,
   input  logic [7:0] dp_en,
`ifdef SEG_DIM_EN
   input  logic [3:0] bright,
`endif
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [7:0] an,
   output logic       frame_tick
);

   localparam int SLOT_CYC = (SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 0;
   localparam logic [7:0] AN_IDLE = (AN_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   generate
      if (SCAN_HZ > CLK_HZ || SLOT_CYC <= GUARD_CYC + 1) begin : g_bad_cfg
         $error("seg_scan_driver: slot too short for guard interval");
      end
   endgenerate

   dig_t       dig;
   phase_e     phase;
   logic       frame_wrap;
   logic [6:0] led_in [N_DIGITS];
   logic [6:0] seg_sh_q [N_DIGITS];
   logic [7:0] dp_sh_q;
   logic       pwm_ok;
   logic [6:0] seg_d;
   logic       dp_d;
   logic [7:0] an_on;
   logic [7:0] an_d;
   logic [6:0] seg_q;
   logic       dp_q;
   logic [7:0] an_q;

   seg_slot_timer #(
      .SLOT_CYC  (SLOT_CYC),
      .GUARD_CYC (GUARD_CYC)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .dig_o        (dig),
      .phase_o      (phase),
      .frame_wrap_o (frame_wrap),
      .frame_tick_o (frame_tick)
   );

   assign led_in[0] = led0;
   assign led_in[1] = led1;
   assign led_in[2] = led2;
   assign led_in[3] = led3;
   assign led_in[4] = led4;
   assign led_in[5] = led5;
   assign led_in[6] = led6;
   assign led_in[7] = led7;

   // Shadows only move on the last cycle of digit 7, so a frame is never mixed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            seg_sh_q[i] <= SEG_DARK;
         end
         dp_sh_q <= '0;
      end else if (frame_wrap) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            seg_sh_q[i] <= led_in[i];
         end
         dp_sh_q <= dp_en;
      end
   end

`ifdef SEG_DIM_EN
   logic [3:0] bright_sh_q;
   logic [3:0] pwm_q;
   logic [3:0] pwm_d;

   assign pwm_d  = (phase == PH_ON) ? pwm_q + 4'd1 : 4'd0;
   assign pwm_ok = (bright_sh_q == 4'hF) || (pwm_q < bright_sh_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bright_sh_q <= '0;
         pwm_q       <= '0;
      end else begin
         pwm_q <= pwm_d;
         if (frame_wrap) begin
            bright_sh_q <= bright;
         end
      end
   end
`else
   assign pwm_ok = 1'b1;
`endif

   always_comb begin
      seg_d = SEG_DARK;
      dp_d  = 1'b1;
      an_on = '0;
      if (phase == PH_ON) begin
         seg_d = seg_sh_q[dig];
         dp_d  = ~dp_sh_q[dig];
         if (pwm_ok) begin
            an_on = dig_onehot(dig);
         end
      end
      an_d = an_on ^ AN_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_DARK;
         dp_q  <= 1'b1;
         an_q  <= AN_IDLE;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg_n = seg_q;
   assign dp_n  = dp_q;
   assign an    = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 10-cycle slot, 2-cycle guard.
// Build with SEG_DIM_EN defined to also cover the brightness PWM.
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] led [8];
   logic [7:0] dp_en;
   logic [3:0] bright;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [7:0] an;
   logic       frame_tick;

   int checks = 0;
   int fails  = 0;

   seg_scan_driver #(
      .CLK_HZ        (1000),
      .SCAN_HZ       (100),
      .GUARD_CYC     (2),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .led0       (led[0]),
      .led1       (led[1]),
      .led2       (led[2]),
      .led3       (led[3]),
      .led4       (led[4]),
      .led5       (led[5]),
      .led6       (led[6]),
      .led7       (led[7]),
      .dp_en      (dp_en),
`ifdef SEG_DIM_EN
      .bright     (bright),
`endif
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 200);
      checks++;
      if (frame_tick !== 1'b1) begin
         fails++;
         $display("FAIL wait_tick: frame_tick=%b required 1 within 200", frame_tick);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      dp_en  = 8'h00;
      bright = 4'hF;
      for (int i = 0; i < 8; i++) led[i] = 7'h7F;
      repeat (2) @(negedge clk);
      checks += 4;
      if (seg_n !== 7'h7F) begin fails++; $display("FAIL rst_seg: got %h want 7f", seg_n); end
      if (an !== 8'hFF) begin fails++; $display("FAIL rst_an: got %h want ff", an); end
      if (dp_n !== 1'b1) begin fails++; $display("FAIL rst_dp: got %b want 1", dp_n); end
      if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (an !== 8'hFF) begin fails++; $display("FAIL c1_an: got %h want ff", an); end
      if (frame_tick !== 1'b1) begin fails++; $display("FAIL c1_tick: got %b want 1", frame_tick); end
      @(negedge clk);
      checks += 2;
      if (an !== 8'hFF) begin fails++; $display("FAIL c2_an: got %h want ff", an); end
      if (frame_tick !== 1'b0) begin fails++; $display("FAIL c2_tick: got %b want 0", frame_tick); end
      @(negedge clk);
      checks += 2;
      if (an !== 8'hFE) begin fails++; $display("FAIL c3_an: got %h want fe", an); end
      if (seg_n !== 7'h7F) begin fails++; $display("FAIL c3_seg: got %h want 7f", seg_n); end
   endtask

   task automatic test_scan_order();
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_tick;
      for (int i = 0; i < 8; i++) led[i] = 7'h40 | 7'(i);
      wait_tick();
      for (int p = 0; p < 80; p++) begin
         int d = p / 10;
         int t = p % 10;
         exp_an   = (t < 2) ? 8'hFF : ~(8'b1 << d);
         exp_seg  = (t < 2) ? 7'h7F : (7'h40 | 7'(d));
         exp_tick = (p == 0);
         checks += 3;
         if (an !== exp_an) begin
            fails++; $display("FAIL scan_an p=%0d: got %h want %h", p, an, exp_an);
         end
         if (seg_n !== exp_seg) begin
            fails++; $display("FAIL scan_seg p=%0d: got %h want %h", p, seg_n, exp_seg);
         end
         if (frame_tick !== exp_tick) begin
            fails++; $display("FAIL scan_tick p=%0d: got %b want %b", p, frame_tick, exp_tick);
         end
         @(negedge clk);
      end
      checks++;
      if (frame_tick !== 1'b1) begin
         fails++; $display("FAIL tick_period: got %b want 1 after 80 cycles", frame_tick);
      end
   endtask

   task automatic test_coherence();
      led[3] = 7'h79;
      repeat (80) @(negedge clk);
      checks++;
      if (frame_tick !== 1'b1) begin fails++; $display("FAIL coh_sync: got %b want 1", frame_tick); end
      for (int p = 0; p < 80; p++) begin
         if (p == 15) led[3] = 7'h30;
         if (p == 32 || p == 39) begin
            checks += 2;
            if (seg_n !== 7'h79) begin fails++; $display("FAIL coh_old p=%0d: got %h want 79", p, seg_n); end
            if (an !== 8'hF7) begin fails++; $display("FAIL coh_old_an p=%0d: got %h want f7", p, an); end
         end
         @(negedge clk);
      end
      repeat (32) @(negedge clk);
      checks += 2;
      if (seg_n !== 7'h30) begin fails++; $display("FAIL coh_new: got %h want 30", seg_n); end
      if (an !== 8'hF7) begin fails++; $display("FAIL coh_new_an: got %h want f7", an); end
   endtask

   task automatic test_decimal_point();
      logic exp_dp;
      wait_tick();
      dp_en = 8'h10;
      wait_tick();
      for (int p = 0; p < 80; p++) begin
         exp_dp = !((p / 10) == 4 && (p % 10) >= 2);
         checks++;
         if (dp_n !== exp_dp) begin
            fails++; $display("FAIL dp p=%0d: got %b want %b", p, dp_n, exp_dp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      wait_tick();
      repeat (55) @(negedge clk);
      checks++;
      if (an !== 8'hDF) begin fails++; $display("FAIL mid_an: got %h want df", an); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (seg_n !== 7'h7F) begin fails++; $display("FAIL arst_seg: got %h want 7f", seg_n); end
      if (an !== 8'hFF) begin fails++; $display("FAIL arst_an: got %h want ff", an); end
      if (dp_n !== 1'b1) begin fails++; $display("FAIL arst_dp: got %b want 1", dp_n); end
      if (frame_tick !== 1'b0) begin fails++; $display("FAIL arst_tick: got %b want 0", frame_tick); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (frame_tick !== 1'b1) begin fails++; $display("FAIL rs_tick: got %b want 1", frame_tick); end
      if (an !== 8'hFF) begin fails++; $display("FAIL rs_an1: got %h want ff", an); end
      repeat (2) @(negedge clk);
      checks += 2;
      if (an !== 8'hFE) begin fails++; $display("FAIL rs_an3: got %h want fe", an); end
      if (seg_n !== 7'h7F) begin fails++; $display("FAIL rs_seg3: got %h want 7f", seg_n); end
   endtask

`ifdef SEG_DIM_EN
   task automatic test_dimming();
      logic [3:0] lv [3];
      logic       exp_act;
      int         n_on;
      lv[0] = 4'd4;
      lv[1] = 4'd0;
      lv[2] = 4'd15;
      for (int k = 0; k < 3; k++) begin
         n_on   = (lv[k] == 4'd15) ? 8 : int'(lv[k]);
         bright = lv[k];
         wait_tick();
         wait_tick();
         for (int p = 0; p < 80; p++) begin
            int d = p / 10;
            int t = p % 10;
            exp_act = (t >= 2) && ((t - 2) < n_on);
            checks++;
            if (an !== (exp_act ? ~(8'b1 << d) : 8'hFF)) begin
               fails++;
               $display("FAIL dim b=%0d p=%0d: an=%h active want %b", lv[k], p, an, exp_act);
            end
            @(negedge clk);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan_order();
      test_coherence();
      test_decimal_point();
      test_async_reset();
`ifdef SEG_DIM_EN
      test_dimming();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
